// File: rtl/burst_dma_pkg.sv
// Shared types and derived-width helpers for the burst-copy DMA.
// Read-side state encoding plus BYTES and counter-width functions.
package burst_dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    PEND,
    DRAIN
  } read_state_t;

  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int idx_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush.
// dout always shows the head word; count/empty/full are registered.
module dma_sync_fifo
  import burst_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       din,
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       dout,
  output logic [idx_width(DEPTH)-1:0] count,
  output logic                        empty,
  output logic                        full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = idx_width(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/burst_copy_dma.sv
// Burst-copy DMA: burst reads from a memory port into a FIFO,
// single-word writes from the FIFO head to a stallable sink.
module burst_copy_dma
  import burst_dma_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int BURST_LENGTH = 16,
  parameter int NUM_WORDS    = 128,
  parameter int FIFO_DEPTH   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  output logic                  busy,
  output logic                  done,
  output logic                  in_rd,
  output logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_wait_n,
  input  logic                  in_valid,
  input  logic                  in_burst_done,
  output logic                  out_wr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  out_wait_n
);

  localparam int BYTES      = bytes_of(DATA_WIDTH);
  localparam int NUM_BURSTS = NUM_WORDS / BURST_LENGTH;
  localparam int BW         = idx_width(NUM_BURSTS);
  localparam int WW         = idx_width(NUM_WORDS);
  localparam int CW         = idx_width(FIFO_DEPTH);

  localparam logic [ADDR_WIDTH-1:0] BURST_STRIDE =
    ADDR_WIDTH'(BURST_LENGTH * BYTES);
  localparam logic [ADDR_WIDTH-1:0] WORD_STRIDE =
    ADDR_WIDTH'(BYTES);
  localparam logic [CW-1:0] REQ_LIMIT =
    CW'(FIFO_DEPTH - BURST_LENGTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [BW-1:0] LAST_BURST = BW'(NUM_BURSTS - 1);
  localparam logic [BW-1:0] BURST_ONE  = BW'(1);
  localparam logic [WW-1:0] LAST_WORD  = WW'(NUM_WORDS - 1);
  localparam logic [WW-1:0] WORD_ONE   = WW'(1);

  read_state_t state;

  logic [BW-1:0]         burst_idx;
  logic [WW-1:0]         word_idx;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         count_next;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  last_pop;

  // The done cycle has busy low but must still refuse a new start.
  assign accept   = start & ~busy & ~done;
  assign push     = (state == PEND) & in_valid & ~fifo_full;
  assign out_wr   = busy & ~fifo_empty;
  assign pop      = out_wr & out_wait_n;
  assign last_pop = pop & (word_idx == LAST_WORD);

  assign in_addr  = src_q + ADDR_WIDTH'(burst_idx) * BURST_STRIDE;
  assign out_addr = dst_q + ADDR_WIDTH'(word_idx) * WORD_STRIDE;

  always_comb begin
    count_next = fifo_count;
    if (push && !pop)
      count_next = fifo_count + CNT_ONE;
    else if (pop && !push)
      count_next = fifo_count - CNT_ONE;
  end

  dma_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .flush(accept),
    .push (push),
    .din  (in_dout),
    .pop  (pop),
    .dout (out_din),
    .count(fifo_count),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  // in_rd is registered from the next FIFO occupancy so it only
  // rises once a whole burst is guaranteed room.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_rd     <= 1'b0;
      burst_idx <= '0;
      word_idx  <= '0;
      src_q     <= '0;
      dst_q     <= '0;
    end else begin
      done <= 1'b0;
      if (pop)
        word_idx <= word_idx + WORD_ONE;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state     <= REQ;
            busy      <= 1'b1;
            in_rd     <= 1'b1;
            src_q     <= src_base;
            dst_q     <= dst_base;
            burst_idx <= '0;
            word_idx  <= '0;
          end
        end
        REQ: begin
          if (in_rd && in_wait_n) begin
            state <= PEND;
            in_rd <= 1'b0;
          end else begin
            in_rd <= (count_next <= REQ_LIMIT);
          end
        end
        PEND: begin
          if (in_burst_done) begin
            burst_idx <= burst_idx + BURST_ONE;
            if (burst_idx == LAST_BURST) begin
              state <= DRAIN;
            end else begin
              state <= REQ;
              in_rd <= (count_next <= REQ_LIMIT);
            end
          end
        end
        DRAIN: begin
          state <= DRAIN;
        end
        default: state <= IDLE;
      endcase
      if (last_pop) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
        in_rd <= 1'b0;
      end
    end
  end

endmodule
